cu_request_arbiter: RTL and testbench

//   Shares the single Chakravyuh control unit (CU) between NUM_REQ host requesters.

---
 rtl/cu_request_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_cu_request_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_request_arbiter.sv
// cu_request_arbiter
// Round-robin arbiter that shares one Chakravyuh control unit between
// NUM_REQ host requesters. It runs the CU enable/cu_ready handshake and
// returns captured dataout/status to the winning requester. An auth lock
// keeps the two-phase AUTH exchange with one requester. Watchdogs bound the
// ISSUE and RELEASE phases and the time a lock can be held by an idle owner.
module cu_request_arbiter #(
  parameter int                      NUM_REQ        = 2,
  parameter int                      OPCODE_WIDTH   = 4,
  parameter int                      DATA_WIDTH     = 8,
  parameter int                      STATUS_WIDTH   = 4,
  parameter logic [OPCODE_WIDTH-1:0] AUTH_OPCODE    = OPCODE_WIDTH'(4'hA),
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0] i_req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_datain,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_addr,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  output logic [STATUS_WIDTH-1:0]         o_rsp_status,
  output logic                            o_rsp_timeout,
  output logic                            o_auth_locked,
  output logic                            o_err_sticky,
  output logic                            o_cu_enable,
  output logic [OPCODE_WIDTH-1:0]         o_cu_opcode,
  output logic [DATA_WIDTH-1:0]           o_cu_datain,
  output logic [DATA_WIDTH-1:0]           o_cu_addr,
  input  logic [DATA_WIDTH-1:0]           i_cu_dataout,
  input  logic [STATUS_WIDTH-1:0]         i_cu_status,
  input  logic                            i_cu_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [STATUS_WIDTH-1:0] r_rsp_status;
  logic                    r_rsp_timeout;
  logic                    r_auth_locked;
  logic                    r_err_sticky;
  logic                    r_cu_enable;
  logic [OPCODE_WIDTH-1:0] r_cu_opcode;
  logic [DATA_WIDTH-1:0]   r_cu_datain;
  logic [DATA_WIDTH-1:0]   r_cu_addr;

  logic [IDX_W-1:0]        r_last;     // most recent grant, RR origin
  logic [IDX_W-1:0]        r_gidx;     // index of current owner
  logic [IDX_W-1:0]        r_lock_id;  // owner of the auth lock
  logic [CNT_W-1:0]        r_wd_cnt;   // cycles spent in current ISSUE/RELEASE
  logic [CNT_W-1:0]        r_lock_cnt; // idle cycles of the lock owner

  logic [NUM_REQ-1:0]      w_eligible;
  logic [IDX_W-1:0]        w_win;
  logic                    w_found;
  logic                    w_start;
  logic                    w_done;
  logic                    w_wd_expire;
  logic                    w_issue_to;
  logic                    w_release_to;
  logic                    w_lock_owner_req;
  logic                    w_lock_hold_to;

  // Eligible requesters: everyone when unlocked, only the lock owner when locked.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    w_eligible = i_req_valid;
    if (r_auth_locked) begin
      w_eligible = i_req_valid & (NUM_REQ'(1) << r_lock_id);
    end
  end

  // Round-robin pick: scan from the requester after the last grant.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = int'(r_last) + k;
      if (v_idx >= NUM_REQ) begin
        v_idx = v_idx - NUM_REQ;
      end
      if (!w_found && w_eligible[v_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[IDX_W-1:0];
      end
    end
  end

  assign w_start          = (r_state == ST_IDLE) && !i_cu_ready && w_found;
  assign w_wd_expire      = (r_wd_cnt == CNT_LAST);
  assign w_done           = (r_state == ST_ISSUE) && i_cu_ready;
  assign w_issue_to       = (r_state == ST_ISSUE) && !i_cu_ready && w_wd_expire;
  assign w_release_to     = (r_state == ST_RELEASE) && i_cu_ready && w_wd_expire;
  assign w_lock_owner_req = i_req_valid[r_lock_id];
  assign w_lock_hold_to   = r_auth_locked && !w_lock_owner_req && (r_lock_cnt == CNT_LAST);

  // Next-state logic for the IDLE -> ISSUE -> RELEASE cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start)                      w_state_next = ST_ISSUE;
      ST_ISSUE:   if (w_done || w_issue_to)         w_state_next = ST_RELEASE;
      ST_RELEASE: if (!i_cu_ready || w_release_to)  w_state_next = ST_IDLE;
      default:                                      w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Phase watchdog: restarts on every state change, idle in IDLE.
  always_ff @(posedge i_clock) begin
    if (i_reset || (r_state != w_state_next) || (r_state == ST_IDLE)) r_wd_cnt <= '0;
    else                                                               r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  // Lock-hold watchdog: counts cycles the lock owner has no request pending.
  always_ff @(posedge i_clock) begin
    if (i_reset || !r_auth_locked || w_lock_owner_req) r_lock_cnt <= '0;
    else if (r_lock_cnt != CNT_LAST)                   r_lock_cnt <= r_lock_cnt + 1'b1;
  end

  // Registered outputs: grant/issue, response capture, lock and error tracking.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant       <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_status  <= '0;
      r_rsp_timeout <= 1'b0;
      r_auth_locked <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_cu_enable   <= 1'b0;
      r_cu_opcode   <= '0;
      r_cu_datain   <= '0;
      r_cu_addr     <= '0;
      r_last        <= IDX_W'(NUM_REQ - 1);
      r_gidx        <= '0;
      r_lock_id     <= '0;
    end else begin
      r_rsp_valid   <= '0;
      r_rsp_timeout <= 1'b0;
      if (w_lock_hold_to) begin
        r_auth_locked <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_grant     <= NUM_REQ'(1) << w_win;
            r_gidx      <= w_win;
            r_last      <= w_win;
            r_cu_enable <= 1'b1;
            r_cu_opcode <= i_req_opcode[w_win*OPCODE_WIDTH +: OPCODE_WIDTH];
            r_cu_datain <= i_req_datain[w_win*DATA_WIDTH +: DATA_WIDTH];
            r_cu_addr   <= i_req_addr[w_win*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ST_ISSUE: begin
          if (w_done) begin
            r_rsp_data   <= i_cu_dataout;
            r_rsp_status <= i_cu_status;
            r_rsp_valid  <= r_grant;
            r_cu_enable  <= 1'b0;
            // An AUTH completion arms (or re-arms) the lock; any other
            // completion while locked is by the owner and ends the exchange.
            if (r_cu_opcode == AUTH_OPCODE) begin
              r_auth_locked <= 1'b1;
              r_lock_id     <= r_gidx;
            end else begin
              r_auth_locked <= 1'b0;
            end
          end else if (w_issue_to) begin
            r_rsp_valid   <= r_grant;
            r_rsp_timeout <= 1'b1;
            r_cu_enable   <= 1'b0;
            r_err_sticky  <= 1'b1;
            r_auth_locked <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (!i_cu_ready || w_release_to) begin
            r_grant <= '0;
          end
          if (w_release_to) begin
            r_err_sticky <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_status  = r_rsp_status;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_auth_locked = r_auth_locked;
  assign o_err_sticky  = r_err_sticky;
  assign o_cu_enable   = r_cu_enable;
  assign o_cu_opcode   = r_cu_opcode;
  assign o_cu_datain   = r_cu_datain;
  assign o_cu_addr     = r_cu_addr;

endmodule

// File: tb/tb_cu_request_arbiter.sv
// Directed bench for cu_request_arbiter with a behavioural CU and two
// behavioural host requesters driven from per-requester request queues.
module tb_cu_request_arbiter;

  localparam int NUM_REQ = 2;
  localparam int OPW     = 4;
  localparam int DW      = 8;
  localparam int SW      = 4;
  localparam int TO      = 16;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_AUTH  = 4'hA;

  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    logic [7:0] addr;
  } req_t;

  typedef struct {
    int         id;
    logic [1:0] grant;
    logic [7:0] data;
    logic [3:0] status;
    logic       timeout;
  } rsp_t;

  typedef enum int {CU_AUTO, CU_HANG, CU_STUCK} cu_mode_t;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OPW-1:0]  req_opcode;
  logic [NUM_REQ*DW-1:0]   req_datain;
  logic [NUM_REQ*DW-1:0]   req_addr;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [DW-1:0]           rsp_data;
  logic [SW-1:0]           rsp_status;
  logic                    rsp_timeout;
  logic                    auth_locked;
  logic                    err_sticky;
  logic                    cu_enable;
  logic [OPW-1:0]          cu_opcode;
  logic [DW-1:0]           cu_datain;
  logic [DW-1:0]           cu_addr;
  logic [DW-1:0]           cu_dataout;
  logic [SW-1:0]           cu_status;
  logic                    cu_ready;

  req_t     q0[$];
  req_t     q1[$];
  rsp_t     rlog[$];
  cu_mode_t cu_mode;
  int       en_cycles;
  logic [7:0] cu_last_addr;
  logic [7:0] cu_last_data;
  int       n_checks;
  int       n_errors;

  cu_request_arbiter #(
    .NUM_REQ(NUM_REQ), .OPCODE_WIDTH(OPW), .DATA_WIDTH(DW), .STATUS_WIDTH(SW),
    .AUTH_OPCODE(OP_AUTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .i_req_opcode(req_opcode),
    .i_req_datain(req_datain), .i_req_addr(req_addr),
    .o_grant(grant), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rsp_status(rsp_status), .o_rsp_timeout(rsp_timeout),
    .o_auth_locked(auth_locked), .o_err_sticky(err_sticky),
    .o_cu_enable(cu_enable), .o_cu_opcode(cu_opcode),
    .o_cu_datain(cu_datain), .o_cu_addr(cu_addr),
    .i_cu_dataout(cu_dataout), .i_cu_status(cu_status), .i_cu_ready(cu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CU: answers one negedge after seeing enable, returns
  // 17 for AUTH, addr+datain otherwise, status = opcode.
  initial begin
    cu_ready = 1'b0; cu_dataout = '0; cu_status = '0;
    cu_last_addr = '0; cu_last_data = '0;
    forever begin
      @(negedge clk);
      case (cu_mode)
        CU_AUTO: begin
          if (cu_enable && !cu_ready) begin
            cu_ready     = 1'b1;
            cu_dataout   = (cu_opcode == OP_AUTH) ? 8'd17 : cu_addr + cu_datain;
            cu_status    = cu_opcode;
            cu_last_addr = cu_addr;
            cu_last_data = cu_datain;
          end else if (!cu_enable && cu_ready) begin
            cu_ready = 1'b0;
          end
        end
        CU_HANG:  cu_ready = 1'b0;
        default:  cu_ready = 1'b1;
      endcase
    end
  end

  // Behavioural hosts: present queue head, log and pop on rsp_valid.
  initial begin
    rsp_t r;
    req_valid = '0; req_opcode = '0; req_datain = '0; req_addr = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        r = '{id: 0, grant: grant, data: rsp_data, status: rsp_status, timeout: rsp_timeout};
        rlog.push_back(r);
        if (q0.size() > 0) q0.delete(0);
      end
      if (rsp_valid[1]) begin
        r = '{id: 1, grant: grant, data: rsp_data, status: rsp_status, timeout: rsp_timeout};
        rlog.push_back(r);
        if (q1.size() > 0) q1.delete(0);
      end
      if (q0.size() > 0) begin
        req_valid[0] = 1'b1; req_opcode[3:0] = q0[0].op;
        req_datain[7:0] = q0[0].data; req_addr[7:0] = q0[0].addr;
      end else begin
        req_valid[0] = 1'b0;
      end
      if (q1.size() > 0) begin
        req_valid[1] = 1'b1; req_opcode[7:4] = q1[0].op;
        req_datain[15:8] = q1[0].data; req_addr[15:8] = q1[0].addr;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
  end

  // Counts cycles with cu_enable high.
  initial begin
    en_cycles = 0;
    forever begin
      @(negedge clk);
      if (cu_enable) en_cycles++;
    end
  end

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rlog.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    cu_mode = CU_AUTO;
    do_reset(3);
    @(posedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    n_checks++; if (rsp_status !== 4'h0) begin n_errors++; $display("FAIL reset_rsp_status: got %h want 0", rsp_status); end
    n_checks++; if (rsp_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_timeout: got %b want 0", rsp_timeout); end
    n_checks++; if (auth_locked !== 1'b0) begin n_errors++; $display("FAIL reset_auth_locked: got %b want 0", auth_locked); end
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_err_sticky: got %b want 0", err_sticky); end
    n_checks++; if (cu_enable !== 1'b0) begin n_errors++; $display("FAIL reset_cu_enable: got %b want 0", cu_enable); end
    n_checks++; if ({cu_opcode, cu_datain, cu_addr} !== 20'h0) begin n_errors++; $display("FAIL reset_cu_fields: got %h want 0", {cu_opcode, cu_datain, cu_addr}); end
  endtask

  task automatic test_single;
    bit ok;
    rlog.delete(); en_cycles = 0;
    q0.push_back('{op: OP_WRITE, data: 8'd23, addr: 8'd100});
    wait_log(1, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL single_done: got %b want 1", ok); end
    if (ok) begin
      n_checks++; if (rlog[0].id !== 0) begin n_errors++; $display("FAIL single_id: got %0d want 0", rlog[0].id); end
      n_checks++; if (rlog[0].grant !== 2'b01) begin n_errors++; $display("FAIL single_grant: got %b want 01", rlog[0].grant); end
      n_checks++; if (rlog[0].data !== 8'd123) begin n_errors++; $display("FAIL single_data: got %0d want 123", rlog[0].data); end
      n_checks++; if (rlog[0].status !== OP_WRITE) begin n_errors++; $display("FAIL single_status: got %h want 2", rlog[0].status); end
      n_checks++; if (rlog[0].timeout !== 1'b0) begin n_errors++; $display("FAIL single_timeout: got %b want 0", rlog[0].timeout); end
    end
    repeat (5) @(posedge clk); #1;
    n_checks++; if (rlog.size() !== 1) begin n_errors++; $display("FAIL single_pulses: got %0d want 1", rlog.size()); end
    n_checks++; if (en_cycles !== 1) begin n_errors++; $display("FAIL single_enable_cycles: got %0d want 1", en_cycles); end
    n_checks++; if (cu_last_addr !== 8'd100) begin n_errors++; $display("FAIL single_cu_addr: got %0d want 100", cu_last_addr); end
    n_checks++; if (cu_last_data !== 8'd23) begin n_errors++; $display("FAIL single_cu_datain: got %0d want 23", cu_last_data); end
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL single_grant_release: got %b want 00", grant); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int exp_id;
    logic [7:0] exp_data;
    rlog.delete();
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{op: OP_READ, data: 8'd0, addr: 8'(10 + k)});
      q1.push_back('{op: OP_READ, data: 8'd0, addr: 8'(40 + k)});
    end
    wait_log(8, 200, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got %b want 1", ok); end
    if (ok) begin
      // Last grant was requester 0, so requester 1 leads and they alternate.
      for (int k = 0; k < 8; k++) begin
        exp_id   = (k % 2 == 0) ? 1 : 0;
        exp_data = (exp_id == 1) ? 8'(40 + k / 2) : 8'(10 + k / 2);
        n_checks++; if (rlog[k].id !== exp_id) begin n_errors++; $display("FAIL b2b_id[%0d]: got %0d want %0d", k, rlog[k].id, exp_id); end
        n_checks++; if (rlog[k].grant !== 2'(1 << exp_id)) begin n_errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", k, rlog[k].grant, 2'(1 << exp_id)); end
        n_checks++; if (rlog[k].data !== exp_data) begin n_errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, rlog[k].data, exp_data); end
      end
    end
  endtask

  task automatic test_auth_lock;
    bit ok;
    rlog.delete();
    q0.push_back('{op: OP_AUTH, data: 8'd0, addr: 8'd0});
    wait_log(1, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL auth_done: got %b want 1", ok); end
    n_checks++; if (rlog[0].data !== 8'd17) begin n_errors++; $display("FAIL auth_nonce: got %0d want 17", rlog[0].data); end
    n_checks++; if (auth_locked !== 1'b1) begin n_errors++; $display("FAIL auth_locked_set: got %b want 1", auth_locked); end
    q1.push_back('{op: OP_READ, data: 8'd0, addr: 8'd50});
    repeat (8) @(posedge clk); #1;
    n_checks++; if (rlog.size() !== 1) begin n_errors++; $display("FAIL auth_req1_stall: got %0d rsps want 1", rlog.size()); end
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL auth_no_grant: got %b want 00", grant); end
    n_checks++; if (cu_enable !== 1'b0) begin n_errors++; $display("FAIL auth_no_enable: got %b want 0", cu_enable); end
    q0.push_back('{op: OP_WRITE, data: 8'd30, addr: 8'd0});
    wait_log(2, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL auth_phase2_done: got %b want 1", ok); end
    n_checks++; if (auth_locked !== 1'b0) begin n_errors++; $display("FAIL auth_lock_cleared: got %b want 0", auth_locked); end
    n_checks++; if (rlog[1].id !== 0) begin n_errors++; $display("FAIL auth_phase2_id: got %0d want 0", rlog[1].id); end
    n_checks++; if (rlog[1].data !== 8'd30) begin n_errors++; $display("FAIL auth_phase2_data: got %0d want 30", rlog[1].data); end
    wait_log(3, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL auth_req1_done: got %b want 1", ok); end
    n_checks++; if (rlog[2].id !== 1) begin n_errors++; $display("FAIL auth_req1_id: got %0d want 1", rlog[2].id); end
    n_checks++; if (rlog[2].data !== 8'd50) begin n_errors++; $display("FAIL auth_req1_data: got %0d want 50", rlog[2].data); end
  endtask

  task automatic test_timeout;
    bit ok;
    rlog.delete();
    q0.push_back('{op: OP_AUTH, data: 8'd0, addr: 8'd0});
    wait_log(1, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL to_auth_done: got %b want 1", ok); end
    n_checks++; if (auth_locked !== 1'b1) begin n_errors++; $display("FAIL to_locked_before: got %b want 1", auth_locked); end
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL to_err_before: got %b want 0", err_sticky); end
    cu_mode = CU_HANG;
    repeat (2) @(posedge clk); #1;
    en_cycles = 0;
    q0.push_back('{op: OP_READ, data: 8'd0, addr: 8'd7});
    wait_log(2, 60, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL to_rsp_seen: got %b want 1", ok); end
    n_checks++; if (rlog[1].id !== 0) begin n_errors++; $display("FAIL to_id: got %0d want 0", rlog[1].id); end
    n_checks++; if (rlog[1].timeout !== 1'b1) begin n_errors++; $display("FAIL to_flag: got %b want 1", rlog[1].timeout); end
    n_checks++; if (rlog[1].data !== 8'd17) begin n_errors++; $display("FAIL to_data_held: got %0d want 17", rlog[1].data); end
    n_checks++; if (rlog[1].status !== OP_AUTH) begin n_errors++; $display("FAIL to_status_held: got %h want a", rlog[1].status); end
    n_checks++; if (en_cycles !== TO) begin n_errors++; $display("FAIL to_enable_cycles: got %0d want %0d", en_cycles, TO); end
    n_checks++; if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL to_err_sticky: got %b want 1", err_sticky); end
    n_checks++; if (auth_locked !== 1'b0) begin n_errors++; $display("FAIL to_lock_cleared: got %b want 0", auth_locked); end
    cu_mode = CU_AUTO;
  endtask

  task automatic test_stuck_ready;
    bit ok;
    rlog.delete();
    cu_mode = CU_STUCK;
    repeat (2) @(posedge clk); #1;
    q0.push_back('{op: OP_WRITE, data: 8'd1, addr: 8'd9});
    repeat (TO + 4) @(posedge clk); #1;
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL stuck_no_grant: got %b want 00", grant); end
    n_checks++; if (cu_enable !== 1'b0) begin n_errors++; $display("FAIL stuck_no_enable: got %b want 0", cu_enable); end
    n_checks++; if (rlog.size() !== 0) begin n_errors++; $display("FAIL stuck_no_rsp: got %0d want 0", rlog.size()); end
    cu_mode = CU_AUTO;
    wait_log(1, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL stuck_recover: got %b want 1", ok); end
    n_checks++; if (rlog[0].data !== 8'd10) begin n_errors++; $display("FAIL stuck_data: got %0d want 10", rlog[0].data); end
    n_checks++; if (rlog[0].timeout !== 1'b0) begin n_errors++; $display("FAIL stuck_timeout: got %b want 0", rlog[0].timeout); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    rlog.delete();
    cu_mode = CU_HANG;
    q0.push_back('{op: OP_READ, data: 8'd0, addr: 8'd3});
    q1.push_back('{op: OP_READ, data: 8'd0, addr: 8'd4});
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cu_enable) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL rmid_issue: got %b want 1", seen); end
    n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL rmid_rr_grant: got %b want 10", grant); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cu_enable !== 1'b0) begin n_errors++; $display("FAIL rmid_enable: got %b want 0", cu_enable); end
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rmid_grant: got %b want 00", grant); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_errors++; $display("FAIL rmid_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL rmid_err: got %b want 0", err_sticky); end
    n_checks++; if ({cu_opcode, cu_datain, cu_addr} !== 20'h0) begin n_errors++; $display("FAIL rmid_cu_fields: got %h want 0", {cu_opcode, cu_datain, cu_addr}); end
    @(negedge clk); rst = 1'b0; cu_mode = CU_AUTO;
    wait_log(2, 60, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rmid_done: got %b want 1", ok); end
    n_checks++; if (rlog[0].id !== 0) begin n_errors++; $display("FAIL rmid_first_id: got %0d want 0", rlog[0].id); end
    n_checks++; if (rlog[0].data !== 8'd3) begin n_errors++; $display("FAIL rmid_first_data: got %0d want 3", rlog[0].data); end
    n_checks++; if (rlog[1].id !== 1) begin n_errors++; $display("FAIL rmid_second_id: got %0d want 1", rlog[1].id); end
    n_checks++; if (rlog[1].data !== 8'd4) begin n_errors++; $display("FAIL rmid_second_data: got %0d want 4", rlog[1].data); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    cu_mode  = CU_AUTO;
    test_reset();
    test_single();
    test_back_to_back();
    test_auth_lock();
    test_timeout();
    test_stuck_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
